mux_nch_rr: RTL and testbench
=============================

# mux_nch_rr

Registered N-channel, W-bit multiplexer, parametrised successor to the team's 4:1 gate-level mux. Selects one of N valid/ready input channels and forwards it through a single output register. Selection is either fixed by a select input or round-robin across requesting channels. Sits between parallel producers and one shared downstream consumer.

## Interface

Parameters:
- `N`, 4: channel count, ≥2.
- `W`, 8: data width per channel, ≥1.
- `SW`, `$clog2(N)`: select/channel-index width (derived; do not override).

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational; at most one bit high.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW  channel index used when `mode`=0.
- `out_data`  out  W  registered output data.
- `out_ch`  out  SW  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.

## Operation

- `load` = !out_valid | out_ready.
- Grant g:
  - `mode`=0: g = `sel` if `in_valid[sel]`, else no grant. `sel` ≥ N gives no grant.
  - `mode`=1: g = first i with `in_valid[i]`=1, scanning ptr, ptr+1, … wrapping modulo N. No grant if `in_valid`=0.
- `in_ready[g]` = load; all other `in_ready` bits are 0. With no grant, `in_ready`=0.
- Accept (in_valid[g] & in_ready[g]): on the next edge, `out_data` ← `in_data[g]`, `out_ch` ← g, `out_valid` ← 1.
- Drain without accept: `out_valid` ← 0 and `out_data`/`out_ch` hold their values.
- No drain while `out_valid`=1: the register holds. `out_data`/`out_ch` must stay stable (AXI-style).
- Round-robin pointer `ptr`:
  - On accept in either mode, ptr ← (g+1) mod N, wrapping from N-1 to 0.
  - `ptr` is unchanged otherwise.
- `mode` and `sel` are sampled every cycle and have no latching. A change affects only the next grant; the beat already held is not altered.
- The block has 2 implicit states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY → FULL on accept.
  - FULL → FULL on drain+accept, or on no drain.
  - FULL → EMPTY on drain without accept.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. `in_ready`=0 while `rst_n`=0.
- Reset asserted mid-operation discards the held beat on that edge. A beat offered during reset is not accepted.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready` is held at 1.
- Simultaneous drain and accept in the same cycle is required to work without a bubble.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `mode`, `sel` and `ptr`. There is no path from `in_ready` back to `in_valid`.

## Configuration

- Macro: `MUX_BEATCNT_EN`.
- When defined:
  - Adds output port `beat_cnt` (out, 16 bits).
  - `beat_cnt` increments on every accept and saturates at 0xFFFF.
  - Reset value is 0.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use N=4, W=8.

1. Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0x00, `in_ready`=0. First accept after release is channel 0 in `mode`=1.
2. Fixed select: `mode`=0, `in_data`={0x44,0x33,0x22,0x11}, `in_valid`=4'b1111, `out_ready`=1, step `sel` 0..3 → `out_data` is 0x11, 0x22, 0x33, 0x44 with `out_ch` 0..3, each 1 cycle after its `sel`. Then `sel`=2 with `in_valid[2]`=0 → no accept and `out_valid` falls.
3. Round-robin fairness: `mode`=1, `in_valid`=4'b1011, `out_ready`=1 for 6 cycles → `out_ch` sequence is 0,1,3,0,1,3 with no bubbles.
4. Backpressure: FULL holding 0x22 with `out_ready`=0 for 3 cycles while inputs change → `out_data`=0x22 stays stable and `in_ready`=0. Then `out_ready`=1 → drain and new accept occur in the same cycle.
5. Wrap and reset mid-stream: `mode`=1, only `in_valid[3]`=1, accept → `ptr`=0. Assert `rst_n`=0 while FULL → `out_valid`=0 next edge and the beat is lost.
6. With `MUX_BEATCNT_EN`: 5 accepts → `beat_cnt`=5. Preload near 0xFFFF by forcing, then 3 more accepts → `beat_cnt` stays at 0xFFFF.

Source files
------------

// File: rtl/mux_nch_rr.sv
// rtl/mux_nch_rr.sv - registered N-channel valid/ready mux, fixed-select or round-robin
// Optional MUX_BEATCNT_EN adds a saturating 16-bit accepted-beat counter port.
module mux_nch_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
`ifdef MUX_BEATCNT_EN
  ,
  output logic [15:0]    beat_cnt
`endif
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] idx;
  logic [SW-1:0] next_ptr;
  logic          grant_vld;
  logic          load;
  logic          accept;

  assign load   = !out_valid || out_ready;
  assign accept = grant_vld && load && rst_n;

  // Round-robin scan runs downward so the candidate closest to ptr wins last.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (mode == 1'b0) begin
      if (int'(sel) < N) begin
        grant     = sel;
        grant_vld = in_valid[sel];
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = SW'((int'(ptr) + k) % N);
        if (in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  assign next_ptr = (int'(grant) == N - 1) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*W +: W];
      out_ch    <= grant;
      ptr       <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_BEATCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (accept && beat_cnt != 16'hFFFF) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nch_rr.sv
// tb/tb_mux_nch_rr.sv - table-driven self-checking bench for mux_nch_rr (N=4, W=8)
module tb_mux_nch_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_BEATCNT_EN
  logic [15:0]    beat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux_nch_rr #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_BEATCNT_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  exp_ir;
    logic          exp_ov;
    logic [W-1:0]  exp_od;
    logic [SW-1:0] exp_ch;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v,
                     input logic r, input logic [N-1:0] ir, input logic ov,
                     input logic [W-1:0] od, input logic [SW-1:0] ch);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ordy = r;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_od = od; t.exp_ch = ch;
    vecs.push_back(t);
  endtask

  // Drive one row just after a rising edge, check in_ready, then outputs after the next edge.
  task automatic apply(input vec_t t, input string tag);
    mode = t.mode; sel = t.sel; in_valid = t.valid; out_ready = t.ordy;
    #1;
    chk({tag, ".in_ready"}, int'(in_ready), int'(t.exp_ir));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, int'(out_valid), int'(t.exp_ov));
    chk({tag, ".out_data"}, int'(out_data), int'(t.exp_od));
    chk({tag, ".out_ch"}, int'(out_ch), int'(t.exp_ch));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = 32'h44332211;

    // fixed select sweep, then a missing valid on the selected channel
    add(0, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);
    add(0, 1, 4'b1111, 1, 4'b0010, 1, 8'h22, 1);
    add(0, 2, 4'b1111, 1, 4'b0100, 1, 8'h33, 2);
    add(0, 3, 4'b1111, 1, 4'b1000, 1, 8'h44, 3);
    add(0, 2, 4'b1011, 1, 4'b0000, 0, 8'h44, 3);
    // round-robin over channels 0,1,3 (ptr starts at 0)
    for (int r = 0; r < 2; r++) begin
      add(1, 0, 4'b1011, 1, 4'b0001, 1, 8'h11, 0);
      add(1, 0, 4'b1011, 1, 4'b0010, 1, 8'h22, 1);
      add(1, 0, 4'b1011, 1, 4'b1000, 1, 8'h44, 3);
    end
    // fill with 0x22, stall three cycles under changing inputs, then drain+accept
    add(0, 1, 4'b1111, 1, 4'b0010, 1, 8'h22, 1);
    add(1, 0, 4'b1111, 0, 4'b0000, 1, 8'h22, 1);
    add(0, 3, 4'b0101, 0, 4'b0000, 1, 8'h22, 1);
    add(1, 0, 4'b0001, 0, 4'b0000, 1, 8'h22, 1);
    add(1, 0, 4'b1111, 1, 4'b0100, 1, 8'h33, 2);
    // only channel 3 valid, ptr wraps to 0
    add(1, 0, 4'b1000, 1, 4'b1000, 1, 8'h44, 3);
    add(1, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);

    // reset held two cycles with all channels offering
    @(posedge clk); #1;
    chk("rst.in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_data", int'(out_data), 0);
    chk("rst.out_ch", int'(out_ch), 0);
    chk("rst.in_ready2", int'(in_ready), 0);
    rst_n = 1'b1;
    begin
      vec_t t;
      t.mode = 1; t.sel = 0; t.valid = 4'b1111; t.ordy = 1;
      t.exp_ir = 4'b0001; t.exp_ov = 1; t.exp_od = 8'h11; t.exp_ch = 0;
      apply(t, "first_rr");
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // reset while FULL: beat dropped, ptr back to 0 (it was 1)
    rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    #1;
    chk("midrst.in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.out_data", int'(out_data), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("midrst.grant", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("midrst.out_ch", int'(out_ch), 0);
    chk("midrst.valid_after", int'(out_valid), 1);

`ifdef MUX_BEATCNT_EN
    // one accept already counted since reset; four more
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("beat_cnt.five", int'(beat_cnt), 5);
    force dut.beat_cnt = 16'hFFFD;
    #1;
    release dut.beat_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("beat_cnt.sat", int'(beat_cnt), 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
